// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, talks to instruction memory over a
// req/ready handshake with wait states, and squashes wrong-path fetches on decode redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic        jumpD,
  input  logic [31:0] pcbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic        busyF
);

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pend_q, pend_d;

  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        d_bubble, d_mem, d_buf;

  assign redir    = valid_q & ~stallD & (pcsrcD | jumpD);
  assign target   = jumpD ? {pcplus4_q[31:28], instr_q[25:0], 2'b00} : pcbranchD;
  assign pc_plus4 = pc_q + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (imem_ready) begin
          if (!redir && stallD) state_d = StHold;
        end else if (redir) begin
          state_d = StDrain;
        end
      end
      StHold:  if (!stallD) state_d = StFetch;
      StDrain: if (imem_ready) state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = 1'b1;
    busyF    = 1'b0;
    case (state_q)
      StFetch: busyF = ~imem_ready;
      StHold:  imem_req = 1'b0;
      StDrain: busyF = 1'b1;
      default: ;
    endcase
  end

  // The PC doubles as the address register, so it stays put while a request is waiting or draining.
  assign imem_addr = pc_q;

  // PC, capture buffer and pending-redirect updates, plus what the IF/ID register loads.
  always_comb begin
    pc_d     = pc_q;
    buf_d    = buf_q;
    pend_d   = pend_q;
    d_bubble = 1'b0;
    d_mem    = 1'b0;
    d_buf    = 1'b0;
    case (state_q)
      StFetch: begin
        if (imem_ready) begin
          if (redir) begin
            pc_d     = target;
            d_bubble = 1'b1;
          end else if (stallD) begin
            buf_d = imem_rdata;
            pc_d  = pc_plus4;
          end else begin
            d_mem = 1'b1;
            pc_d  = pc_plus4;
          end
        end else if (redir) begin
          pend_d   = target;
          d_bubble = 1'b1;
        end else begin
          d_bubble = ~stallD;
        end
      end
      StHold: begin
        if (!stallD) begin
          if (redir) begin
            pc_d     = target;
            d_bubble = 1'b1;
          end else begin
            d_buf = 1'b1;
          end
        end
      end
      StDrain: begin
        // Completing the abandoned request is the redirect itself, so it is not held by a stall.
        if (imem_ready) pc_d = pend_q;
        d_bubble = ~stallD;
      end
      default: ;
    endcase
  end

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (d_bubble) begin
      instr_d   = 32'h0;
      pcplus4_d = 32'h0;
      valid_d   = 1'b0;
    end else if (d_mem) begin
      instr_d   = imem_rdata;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
    end else if (d_buf) begin
      // pc_q already advanced past the buffered word when it was captured.
      instr_d   = buf_q;
      pcplus4_d = pc_q;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
      buf_q     <= 32'h0;
      pend_q    <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
      buf_q     <= buf_d;
      pend_q    <= pend_d;
    end
  end

  assign instrD   = instr_q;
  assign pcplus4D = pcplus4_q;
  assign validD   = valid_q;
  assign opD      = instr_q[31:26];
  assign functD   = instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect/wait-state traffic,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stallD = 1'b0;
  logic        pcsrcD = 1'b0;
  logic        jumpD = 1'b0;
  logic [31:0] pcbranchD = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic [5:0]  opD;
  logic [5:0]  functD;
  logic        busyF;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .stallD    (stallD),
    .pcsrcD    (pcsrcD),
    .jumpD     (jumpD),
    .pcbranchD (pcbranchD),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instrD    (instrD),
    .pcplus4D  (pcplus4D),
    .validD    (validD),
    .opD       (opD),
    .functD    (functD),
    .busyF     (busyF)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: fetch pointer, at most one captured-but-undelivered word, an optional squash target,
  // and the decode-stage contents.
  logic [31:0] m_pc;
  logic [63:0] m_bufq[$];
  bit          m_squash;
  logic [31:0] m_pend;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  bit          m_valid;

  // Memory: one outstanding request with a random number of wait cycles.
  bit mem_out = 1'b0;
  int wleft = 0;
  int min_wait = 0;
  int max_wait = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'h0;
    m_bufq.delete();
    m_squash = 1'b0;
    m_pend   = 32'h0;
    m_instr  = 32'h0;
    m_pc4    = 32'h0;
    m_valid  = 1'b0;
  endtask

  task automatic bubble();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic tick(input bit rst, input bit stall, input bit psrc, input bit jmp,
                      input logic [31:0] br);
    bit          m_req, m_ready, m_busy, redir;
    logic [31:0] tgt;
    logic [63:0] ent;
    @(negedge clk);
    reset     = rst;
    stallD    = stall;
    pcsrcD    = psrc;
    jumpD     = jmp;
    pcbranchD = br;
    m_req = (m_bufq.size() == 0);
    if (m_req && !mem_out) begin
      mem_out = 1'b1;
      wleft   = int'($urandom_range(max_wait, min_wait));
    end
    m_ready    = m_req && (wleft == 0);
    imem_ready = m_ready;
    imem_rdata = m_ready ? word(m_pc) : 32'hDEAD_BEEF;
    #1;
    if (chk_en) begin
      m_busy = (m_bufq.size() == 0) && (m_squash || !m_ready);
      chk("imem_req", imem_req, m_req);
      if (m_req) chk("imem_addr", imem_addr, m_pc);
      chk("busyF", busyF, m_busy);
      chk("instrD", instrD, m_instr);
      chk("pcplus4D", pcplus4D, m_pc4);
      chk("validD", validD, m_valid);
      chk("opD", opD, m_instr[31:26]);
      chk("functD", functD, m_instr[5:0]);
    end
    if (rst) begin
      model_reset();
      mem_out = 1'b0;
    end else begin
      redir = m_valid && !stall && (psrc || jmp);
      tgt   = jmp ? {m_pc4[31:28], m_instr[25:0], 2'b00} : br;
      if (m_squash) begin
        if (m_ready) begin
          m_pc     = m_pend;
          m_squash = 1'b0;
        end
        if (!stall) bubble();
      end else if (m_bufq.size() != 0) begin
        if (!stall) begin
          ent = m_bufq.pop_front();
          if (redir) begin
            m_pc = tgt;
            bubble();
          end else begin
            m_instr = ent[63:32];
            m_pc4   = ent[31:0];
            m_valid = 1'b1;
          end
        end
      end else if (m_ready) begin
        if (redir) begin
          m_pc = tgt;
          bubble();
        end else if (stall) begin
          m_bufq.push_back({word(m_pc), m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
        end else begin
          m_instr = word(m_pc);
          m_pc4   = m_pc + 32'd4;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end
      end else if (redir) begin
        m_squash = 1'b1;
        m_pend   = tgt;
        bubble();
      end else if (!stall) begin
        bubble();
      end
      if (m_ready) mem_out = 1'b0;
      else if (mem_out) wleft--;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rnd_tick(input int p_stall, input int p_redir, input int p_rst);
    bit          rst, st, ps, jp;
    logic [31:0] br;
    rst = int'($urandom_range(0, 999)) < p_rst;
    st  = int'($urandom_range(0, 99)) < p_stall;
    ps  = int'($urandom_range(0, 99)) < p_redir;
    jp  = int'($urandom_range(0, 99)) < p_redir / 2;
    br  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
    tick(rst, st, ps, jp, br);
  endtask

  initial begin
    model_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_en = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("reset_instrD", instrD, 32'h0);
    chk("reset_validD", validD, 32'h0);
    chk("reset_req", imem_req, 32'h1);
    chk("reset_addr", imem_addr, 32'h0);

    // Zero-wait stream
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("stream_i0", instrD, 32'hA000_0000);
    chk("stream_p0", pcplus4D, 32'h4);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("stream_i1", instrD, 32'hA000_0004);
    chk("stream_p1", pcplus4D, 32'h8);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("stream_i2", instrD, 32'hA000_0008);
    chk("stream_p2", pcplus4D, 32'hC);
    chk("stream_v2", validD, 32'h1);

    // Two wait states on every read
    min_wait = 2;
    max_wait = 2;
    idle(12);

    // Stall across the response for 0x8
    do_reset();
    min_wait = 0;
    max_wait = 0;
    idle(2);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(3);

    // Taken branch at 0x8 to 0x40
    do_reset();
    idle(3);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h40);
    idle(3);

    // Jump while the next fetch waits, then drain
    do_reset();
    idle(5);
    min_wait = 3;
    max_wait = 3;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    idle(6);

    // Reset while draining
    do_reset();
    min_wait = 0;
    max_wait = 0;
    idle(1);
    min_wait = 3;
    max_wait = 3;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rst_drain_addr", imem_addr, 32'h0);
    chk("rst_drain_req", imem_req, 32'h1);
    chk("rst_drain_valid", validD, 32'h0);
    chk("rst_drain_instr", instrD, 32'h0);

    // Randomized traffic with varying wait, stall and redirect rates
    for (int ph = 0; ph < 4; ph++) begin
      min_wait = 0;
      max_wait = ph;
      for (int i = 0; i < 500; i++) rnd_tick(10 + 10 * ph, 15 + 5 * ph, 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
